// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared constants for the data-memory arbiter
// Purpose: FSM state encoding and default memory depth used by data_mem_arbiter.
// Ports: none (package).
package mem_ctrl_pkg;

   localparam int DEFAULT_DEPTH = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant logic
// Purpose: pick one of two requesters, favouring the one not granted last.
// Ports:
//   valid[1:0] in  : request pending per requester
//   last       in  : index of the requester granted most recently
//   grant[1:0] out : one-hot grant (all zero when nothing is valid)
module rr_arbiter_2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares one single-port data memory between two requesters
// Purpose: accept one request at a time (round-robin), issue a single memory strobe,
//          return a one-cycle response; out-of-range addresses answer with an error.
// Ports:
//   clock, reset             : clock, asynchronous active-high reset
//   req_valid/ready/write    : per-requester handshake and direction (1 = store)
//   req_addr/req_wdata       : per-requester word address and store data
//   rsp_valid/err/rdata      : per-requester one-cycle response
//   mem_write/read/address/write_data : memory command, live only in ISSUE
//   mem_result               : memory read data, valid the cycle after mem_read
module data_mem_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [1:0]          req_write,
   input  logic [1:0][AW-1:0]  req_addr,
   input  logic [1:0][DW-1:0]  req_wdata,
   output logic [1:0]          rsp_valid,
   output logic [1:0]          rsp_err,
   output logic [1:0][DW-1:0]  rsp_rdata,
   output logic                mem_write,
   output logic                mem_read,
   output logic [AW-1:0]       mem_address,
   output logic [DW-1:0]       mem_write_data,
   input  logic [DW-1:0]       mem_result
);

   logic [1:0]    state_q, state_d;
   logic          last_q, last_d;
   logic          owner_q, owner_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;

   logic [1:0] arb_valid;
   logic [1:0] grant;
   logic       sel;
   logic       accept;

   // Arbitration is only offered while idle so a busy block never grants.
   assign arb_valid = (state_q == ST_IDLE) ? req_valid : 2'b00;

   rr_arbiter_2 u_rr (
      .valid (arb_valid),
      .last  (last_q),
      .grant (grant)
   );

   assign accept = |grant;
   assign sel    = grant[1];

   // Gated by reset so an asserted reset forces ready low even with valid held.
   assign req_ready = reset ? 2'b00 : grant;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               owner_d = sel;
               last_d  = sel;
               wr_d    = req_write[sel];
               addr_d  = req_addr[sel];
               wdata_d = req_wdata[sel];
               state_d = (req_addr[sel] < AW'(DEPTH)) ? ST_ISSUE : ST_ERR;
            end
         end
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         ST_ERR:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Memory side: everything decoded from the registered state, so reset
   // clears the bus in the same cycle it is asserted.
   always_comb begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      if (state_q == ST_ISSUE) begin
         mem_read       = ~wr_q;
         mem_write      = wr_q;
         mem_address    = addr_q;
         mem_write_data = wdata_q;
      end
   end

   // Response side: only the owner's lane is ever driven.
   always_comb begin
      rsp_valid = 2'b00;
      rsp_err   = 2'b00;
      rsp_rdata = '0;
      if (state_q == ST_RESP) begin
         rsp_valid[owner_q] = 1'b1;
         rsp_rdata[owner_q] = wr_q ? '0 : mem_result;
      end else if (state_q == ST_ERR) begin
         rsp_valid[owner_q] = 1'b1;
         rsp_err[owner_q]   = 1'b1;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

   logic             clock = 1'b0;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_write;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_err;
   logic [1:0][31:0] rsp_rdata;
   logic             mem_write;
   logic             mem_read;
   logic [31:0]      mem_address;
   logic [31:0]      mem_write_data;
   logic [31:0]      mem_result;

   int errors = 0;
   int checks = 0;

   data_mem_arbiter dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_err        (rsp_err),
      .rsp_rdata      (rsp_rdata),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_result     (mem_result)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory: registered read, write on strobe.
   logic [31:0] tmem [32];
   always @(posedge clock) begin
      if (mem_write) tmem[mem_address[4:0]] <= mem_write_data;
      if (mem_read)  mem_result <= tmem[mem_address[4:0]];
   end

   // Reference model: schedules the expected strobe and response times of
   // each accepted request and keeps its own copy of memory contents.
   logic [31:0] model_mem [32];
   int          mcyc = 0, free_cyc = 0, strobe_cyc = -1, rsp_cyc = -1;
   logic        m_last = 1'b1, m_own, m_w, m_oob;
   logic [31:0] m_a, m_d;

   always @(negedge clock) begin
      logic [1:0]  e_ready, e_rv;
      logic        e_rd, e_wr;
      logic [31:0] e_addr, e_wd, e_rdata;
      int          own;
      if (reset) begin
         check("reset_outs", {53'd0, req_ready, rsp_valid, rsp_err, mem_read, mem_write,
                              |mem_address, |mem_write_data, |rsp_rdata}, 64'd0);
         strobe_cyc = -1;
         rsp_cyc    = -1;
         free_cyc   = mcyc;
         m_last     = 1'b1;
      end else begin
         e_ready = 2'b00; e_rv = 2'b00; e_rd = 1'b0; e_wr = 1'b0;
         e_addr  = 32'd0; e_wd = 32'd0;
         if (mcyc == strobe_cyc) begin
            e_rd = !m_w; e_wr = m_w; e_addr = m_a; e_wd = m_d;
            if (m_w) model_mem[m_a[4:0]] = m_d;
         end
         if (mcyc == rsp_cyc) begin
            e_rv[m_own] = 1'b1;
            e_rdata = (m_oob || m_w) ? 32'd0 : model_mem[m_a[4:0]];
            check("rsp_err", {63'd0, rsp_err[m_own]}, {63'd0, m_oob});
            check("rsp_rdata", {32'd0, rsp_rdata[m_own]}, {32'd0, e_rdata});
         end
         if (mcyc >= free_cyc && req_valid != 2'b00) begin
            if (req_valid == 2'b11) own = m_last ? 0 : 1;
            else                    own = req_valid[1] ? 1 : 0;
            e_ready[own] = 1'b1;
            m_own  = own[0];
            m_last = own[0];
            m_w    = req_write[own];
            m_a    = req_addr[own];
            m_d    = req_wdata[own];
            m_oob  = (m_a >= 32'd32);
            if (!m_oob) begin
               strobe_cyc = mcyc + 1; rsp_cyc = mcyc + 2; free_cyc = mcyc + 3;
            end else begin
               strobe_cyc = -1;       rsp_cyc = mcyc + 1; free_cyc = mcyc + 2;
            end
         end
         check("req_ready", {62'd0, req_ready}, {62'd0, e_ready});
         check("mem_strobe", {62'd0, mem_read, mem_write}, {62'd0, e_rd, e_wr});
         check("mem_address", {32'd0, mem_address}, {32'd0, e_addr});
         check("mem_wdata", {32'd0, mem_write_data}, {32'd0, e_wd});
         check("rsp_valid", {62'd0, rsp_valid}, {62'd0, e_rv});
      end
      mcyc++;
   end

   int grant_log [$];

   // Drives one request, scrambles the payload right after acceptance, and
   // returns the response plus its latency in cycles after acceptance.
   task automatic do_req(input int idx, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rdata,
                         output logic err, output int lat);
      int n;
      bit got;
      rdata = 32'hx; err = 1'bx; lat = -1;
      req_write[idx] = w; req_addr[idx] = a; req_wdata[idx] = d; req_valid[idx] = 1'b1;
      got = 0; n = 0;
      while (!got && n < 50) begin
         @(negedge clock); n++;
         if (req_ready[idx]) got = 1;
      end
      if (!got) begin
         check("accept_timeout", 64'd0, 64'd1);
         req_valid[idx] = 1'b0;
         return;
      end
      grant_log.push_back(idx);
      @(posedge clock); #1;
      req_valid[idx] = 1'b0; req_addr[idx] = ~a; req_wdata[idx] = ~d; req_write[idx] = ~w;
      got = 0; n = 0;
      while (!got && n < 10) begin
         @(negedge clock); n++;
         if (rsp_valid[idx]) begin
            got = 1; rdata = rsp_rdata[idx]; err = rsp_err[idx]; lat = n;
         end
      end
      if (!got) check("rsp_timeout", 64'd0, 64'd1);
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      bit          ok;
      for (int i = 0; i < 32; i++) begin
         tmem[i] = i;
         model_mem[i] = i;
      end
      mem_result = 32'd0;
      req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
      reset = 1'b1;
      #1 req_valid = 2'b11;
      @(negedge clock);
      check("reset_ready_forced", {62'd0, req_ready}, 64'd0);
      check("reset_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      req_valid = 2'b00;
      @(posedge clock); #1 reset = 1'b0;

      do_req(0, 1'b0, 32'd5, 32'd0, rd, er, lat);
      check("load5_rdata", {32'd0, rd}, 64'd5);
      check("load5_latency", lat, 64'd2);

      do_req(1, 1'b1, 32'd7, 32'hDEAD_BEEF, rd, er, lat);
      check("store7_latency", lat, 64'd2);
      check("store7_rdata", {32'd0, rd}, 64'd0);
      do_req(1, 1'b0, 32'd7, 32'd0, rd, er, lat);
      check("load7_rdata", {32'd0, rd}, 64'hDEAD_BEEF);
      check("load7_err", {63'd0, er}, 64'd0);

      do_req(0, 1'b0, 32'd32, 32'd0, rd, er, lat);
      check("oob32_err", {63'd0, er}, 64'd1);
      check("oob32_rdata", {32'd0, rd}, 64'd0);
      check("oob32_latency", lat, 64'd1);
      do_req(0, 1'b0, 32'hFFFF_FFFF, 32'd0, rd, er, lat);
      check("oobmax_err", {63'd0, er}, 64'd1);
      check("oobmax_latency", lat, 64'd1);

      do_req(0, 1'b0, 32'd31, 32'd0, rd, er, lat);
      check("load31_rdata", {32'd0, rd}, 64'd31);
      check("load31_err", {63'd0, er}, 64'd0);

      // Reset during the ISSUE cycle of a store.
      req_write[0] = 1'b1; req_addr[0] = 32'd3; req_wdata[0] = 32'h1234; req_valid[0] = 1'b1;
      ok = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clock);
         if (req_ready[0]) ok = 1;
      end
      check("midop_accept", {63'd0, ok}, 64'd1);
      @(posedge clock); #1;
      req_valid[0] = 1'b0;
      check("midop_in_issue", {63'd0, mem_write}, 64'd1);
      reset = 1'b1;
      #1 check("midop_strobe_dropped", {62'd0, mem_read, mem_write}, 64'd0);
      @(posedge clock); #1 reset = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clock);
         check("midop_no_rsp", {62'd0, rsp_valid}, 64'd0);
      end
      @(posedge clock); #1;
      do_req(0, 1'b0, 32'd3, 32'd0, rd, er, lat);
      check("midop_load3_unchanged", {32'd0, rd}, 64'd3);

      // Contention straight after reset: requester 0 must go first.
      reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      grant_log.delete();
      fork
         begin
            logic [31:0] r0; logic e0; int l0;
            for (int k = 0; k < 4; k++) begin
               do_req(0, 1'b0, 32'd20 + k, 32'd0, r0, e0, l0);
               check("cont_load_rdata", {32'd0, r0}, 64'd20 + k);
            end
         end
         begin
            logic [31:0] r1; logic e1; int l1;
            for (int k = 0; k < 4; k++)
               do_req(1, 1'b1, 32'd10 + k, 32'h0111_0000 + k, r1, e1, l1);
         end
      join
      check("cont_grant_count", grant_log.size(), 64'd8);
      for (int k = 0; k < grant_log.size() && k < 8; k++)
         check("cont_grant_order", grant_log[k], k % 2);

      do_req(1, 1'b0, 32'd12, 32'd0, rd, er, lat);
      check("cont_store_readback", {32'd0, rd}, 64'h0111_0002);

      repeat (3) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 32, number of data-memory words; legal addresses are 0..DEPTH-1.
- AW, 32, address width.
- DW, 32, data width.
REQ-002 Ports SHALL be, one per line (index i = 0, 1 for the two requesters):
- clock  in  1  single clock; all state updates on its posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid[i]  in  1  requester i has a request pending.
- req_ready[i]  out  1  request of requester i accepted this cycle.
- req_write[i]  in  1  1 = store, 0 = load.
- req_addr[i]  in  AW  word address.
- req_wdata[i]  in  DW  store data.
- rsp_valid[i]  out  1  one-cycle response pulse to requester i.
- rsp_err[i]  out  1  address out of range; qualified by rsp_valid[i].
- rsp_rdata[i]  out  DW  load data; qualified by rsp_valid[i].
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_address  out  AW  memory address.
- mem_write_data  out  DW  memory write data.
- mem_result  in  DW  memory read data; registered by the memory, valid the cycle after mem_read.

Function
REQ-003 Block SHALL share one single-port data memory between two requesters, using FSM states IDLE, ISSUE, RESP and ERR.
REQ-004 In IDLE, req_ready SHALL assert combinationally for exactly one granted requester with req_valid high; acceptance is req_valid&req_ready.
REQ-005 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last; when one is valid, grant it.
REQ-006 At acceptance, write, address and wdata SHALL be captured into internal registers; later requester input changes SHALL be ignored.
REQ-007 Accepted in-range request (addr < DEPTH): IDLE->ISSUE; ISSUE asserts exactly one of mem_read or mem_write for one cycle, with the captured address and data; ISSUE->RESP.
REQ-008 In RESP, rsp_valid of the granted requester SHALL pulse for one cycle; on a load, rsp_rdata = mem_result; on a store, rsp_rdata = 0; rsp_err = 0; RESP->IDLE.
REQ-009 Latency: accept at cycle T, strobe at T+1, rsp_valid at T+2; maximum throughput is one access per 3 cycles.
REQ-010 Out-of-range request (addr >= DEPTH, full AW bits compared): IDLE->ERR; no memory strobe; in ERR, rsp_valid=1, rsp_err=1, rsp_rdata=0; ERR->IDLE.
REQ-011 mem_read and mem_write SHALL never be high together; both SHALL be 0 outside ISSUE.
REQ-012 Outside ISSUE, mem_address and mem_write_data SHALL be 0.
REQ-013 The non-granted requester's rsp_valid and req_ready SHALL stay 0.
REQ-014 A requester whose request arrives while the block is busy SHALL wait with req_valid held; no request SHALL be dropped or duplicated.
REQ-015 Round-robin pointer SHALL update only on acceptance, including error acceptances.

Reset
REQ-016 Asserting reset SHALL immediately force: state IDLE, all req_ready/rsp_valid/rsp_err = 0, rsp_rdata = 0, mem_read = mem_write = 0, mem_address = mem_write_data = 0.
REQ-017 Reset SHALL set the last-grant pointer to requester 1, so requester 0 wins the first contention.
REQ-018 Reset mid-transaction SHALL discard the transaction with no response; a store strobe cut by reset SHALL be treated as not issued.

Structure
REQ-019 Shared package mem_ctrl_pkg SHALL hold the FSM state encoding (IDLE, ISSUE, RESP, ERR) and the default DEPTH constant.
REQ-020 Round-robin grant logic SHALL be a sub-module rr_arbiter_2 (inputs: valid[1:0], last; output: one-hot grant[1:0]).

Verification
REQ-021 Single load: req0 load addr 5 at T -> mem_read=1, mem_address=5 at T+1; rsp_valid[0]=1, rsp_rdata=5 at T+2 (memory preloaded d[i]=i).
REQ-022 Store then load: req1 store addr 7 data 0xDEAD_BEEF, then load addr 7 -> mem_write pulse at accept+1; the load returns 0xDEADBEEF with rsp_err=0.
REQ-023 Contention: both valid continuously for 4 requests each -> grants alternate 0,1,0,1,...; requester 0 goes first after reset; no cycle has both req_ready high.
REQ-024 Out of range: req0 load addr 32 and addr 0xFFFF_FFFF -> no mem strobe; rsp_valid[0]=rsp_err[0]=1 at accept+1 for each; rsp_rdata=0.
REQ-025 Reset mid-op: reset asserted during ISSUE of a store -> strobes drop in the same cycle; no rsp_valid; FSM is in IDLE after reset release; the next request is served normally.
REQ-026 Payload stability: change req_addr in the cycle after acceptance -> mem_address still shows the captured value.
